if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, fetches from instruction memory over a req/ready handshake and
//  drives the IF/ID register (pc_out, inst, inst_valid) consumed by the decode stage. Honours the hazard-unit
//  freeze, and the EXE-stage branch redirect with flush. Tolerates multi-cycle memory latency via a 1-entry skid.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INST   32'h0000_0000  encoding driven on inst when the IF/ID register is flushed/empty
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst            in   1   synchronous reset, active-high
//  freeze         in   1   hazard stall: hold PC and IF/ID register
//  branch_taken   in   1   redirect pulse from EXE; overrides freeze
//  branch_target  in   32  new PC when branch_taken
//  imem_req       out  1   fetch request, level; held until imem_ready
//  imem_addr      out  32  fetch address (= PC), stable while imem_req=1
//  imem_rdata     in   32  instruction word, valid when imem_ready=1
//  imem_ready     in   1   one-cycle completion strobe; may coincide with first req cycle
//  pc_out         out  32  IF/ID: fetch address + 4 of inst
//  inst           out  32  IF/ID: instruction word
//  inst_valid     out  1   IF/ID: 1 = inst is a real fetched instruction
// BEHAVIOUR
//  Reset (rst=1 at edge): PC=RESET_PC, state=FETCH, skid empty, pc_out=0, inst=NOP_INST, inst_valid=0.
//   imem_req=1 from the first cycle after reset; any access abandoned by reset is ignored by the memory.
//  FSM states:
//   FETCH    imem_req=1, imem_addr=PC. On imem_ready & !branch_taken:
//            !freeze -> IF/ID <= {PC+4, rdata, 1}; PC <= PC+4; stay FETCH (next req next cycle).
//            freeze  -> skid <= {PC+4, rdata}; PC <= PC+4; go BUFFERED.
//   BUFFERED imem_req=0. When !freeze: IF/ID <= skid, valid=1; skid emptied; go FETCH.
//   DRAIN    imem_req=1, imem_addr = stale address (held, protocol requires stability). On imem_ready:
//            word discarded, go FETCH at current PC. IF/ID stays flushed-NOP apart from normal hold.
//  Throughput: 1 instr/cycle with zero-wait memory (ready in same cycle as req).
//  Freeze without ready: IF/ID and PC hold; request stays asserted (no cancellation).
//  branch_taken (any state, wins over freeze and imem_ready):
//   PC <= branch_target; IF/ID <= {0, NOP_INST, 0}; skid emptied.
//   FETCH with no ready this cycle -> DRAIN (outstanding access is stale).
//   FETCH with imem_ready same cycle -> word discarded; FETCH at target next cycle.
//   BUFFERED -> FETCH at target. DRAIN -> stays DRAIN, PC updated to newest target.
//  Latency: branch_taken at edge N -> imem_addr=target from N+1 (FETCH) or after drain completes.
//  PC arithmetic: 32-bit, PC+4 wraps modulo 2^32 silently (0xFFFF_FFFC -> 0x0000_0000). No alignment check.
//  inst_valid=0 whenever IF/ID holds NOP_INST from reset or flush; decode treats it as a bubble.
// STRUCTURE
//  Shared package pipeline_pkg: NOP_INST default, RESET_PC default, fetch FSM state enum
//   {FETCH, BUFFERED, DRAIN}, IF/ID bundle struct {pc, inst, valid}.
//  Sub-module if_skid_buffer: 1-entry {pc, inst} holding register with load/unload/clear, full flag.
//  Top holds PC register, FSM, IF/ID register, request muxing.
// TESTING
//  1 Reset, zero-wait memory (ready=req), 4 cycles -> imem_addr 0,4,8,12; pc_out 4,8,12,16 one cycle later;
//    inst_valid=0 in first cycle after reset, then 1.
//  2 Memory 3-cycle latency -> imem_addr held 3 cycles, IF/ID updates once per completion, valid steady.
//  3 freeze=1 for 3 cycles while ready arrives at addr 0x8 -> word in skid, imem_req=0, IF/ID unchanged;
//    freeze drops -> IF/ID = {0xC, word}, next req addr 0xC.
//  4 branch_taken (target 0x100) while req to 0x10 pending -> IF/ID=NOP/valid=0, DRAIN holds addr 0x10
//    until ready, that word discarded, next req addr 0x100.
//  5 branch_taken coincident with imem_ready and freeze -> word dropped, no DRAIN, req 0x100 next cycle.
//  6 PC=0xFFFF_FFFC fetch completes -> pc_out=0x0, next imem_addr=0x0; rst mid-DRAIN -> addr RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: reset/NOP defaults, fetch FSM states and the
// IF/ID register bundle handed from fetch to decode.
package pipeline_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUFFERED = 2'd1,
    DRAIN    = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  // Sequential successor of a fetch address; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master)
// and the instruction memory (slave).
interface if_fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/if_skid_buffer.sv
// One-entry {pc, inst} holding register. Catches a completed fetch while
// decode is frozen so the memory access never has to be cancelled.
module if_skid_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        full
);

  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic        full_r;

  // Entry storage: clear/unload empty it, load captures a word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r   <= 32'h0000_0000;
      inst_r <= 32'h0000_0000;
      full_r <= 1'b0;
    end else if (clear || unload) begin
      full_r <= 1'b0;
    end else if (load) begin
      pc_r   <= pc_in;
      inst_r <= inst_in;
      full_r <= 1'b1;
    end else begin
      full_r <= full_r;
    end
  end

  assign pc_out   = pc_r;
  assign inst_out = inst_r;
  assign full     = full_r;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues fetches over the imem
// req/ready bus and drives the IF/ID register for decode. A frozen decode
// parks a completed word in the skid buffer; a branch flushes IF/ID and, if
// a fetch is still outstanding, drains it before fetching from the target.
module if_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     freeze,
  input  logic                     branch_taken,
  input  logic [31:0]              branch_target,
  if_fetch_stage_if.master         imem,
  output logic [31:0]              pc_out,
  output logic [31:0]              inst,
  output logic                     inst_valid
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, pc_nxt_s;
  logic [31:0]  stale_addr_r, stale_addr_nxt_s;
  if_id_t       ifid_r, ifid_nxt_s;
  if_id_t       flush_s;
  logic [31:0]  pc_inc_s;

  logic         skid_load_s;
  logic         skid_unload_s;
  logic         skid_clear_s;
  logic [31:0]  skid_pc_s;
  logic [31:0]  skid_inst_s;
  logic         skid_full_s;

  assign pc_inc_s = next_pc(pc_r);
  assign flush_s  = '{pc: 32'h0000_0000, inst: NOP_INST, valid: 1'b0};

  if_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load_s),
    .unload   (skid_unload_s),
    .clear    (skid_clear_s),
    .pc_in    (pc_inc_s),
    .inst_in  (imem.imem_rdata),
    .pc_out   (skid_pc_s),
    .inst_out (skid_inst_s),
    .full     (skid_full_s)
  );

  // State, PC, drain address and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FETCH;
      pc_r         <= RESET_PC;
      stale_addr_r <= RESET_PC;
      ifid_r       <= flush_s;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      stale_addr_r <= stale_addr_nxt_s;
      ifid_r       <= ifid_nxt_s;
    end
  end

  // Next-state logic; a branch redirect wins over freeze and imem_ready.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    stale_addr_nxt_s = stale_addr_r;
    ifid_nxt_s       = ifid_r;
    skid_load_s      = 1'b0;
    skid_unload_s    = 1'b0;
    skid_clear_s     = 1'b0;
    if (branch_taken) begin
      pc_nxt_s     = branch_target;
      ifid_nxt_s   = flush_s;
      skid_clear_s = 1'b1;
      case (state_r)
        FETCH: begin
          if (imem.imem_ready) begin
            state_nxt_s = FETCH;
          end else begin
            // Access still in flight: keep its address on the bus until it completes.
            state_nxt_s      = DRAIN;
            stale_addr_nxt_s = pc_r;
          end
        end
        BUFFERED: state_nxt_s = FETCH;
        DRAIN:    state_nxt_s = DRAIN;
        default:  state_nxt_s = FETCH;
      endcase
    end else begin
      case (state_r)
        FETCH: begin
          if (imem.imem_ready) begin
            pc_nxt_s = pc_inc_s;
            if (!freeze) begin
              ifid_nxt_s  = '{pc: pc_inc_s, inst: imem.imem_rdata, valid: 1'b1};
              state_nxt_s = FETCH;
            end else begin
              skid_load_s = 1'b1;
              state_nxt_s = BUFFERED;
            end
          end else begin
            state_nxt_s = FETCH;
          end
        end
        BUFFERED: begin
          if (!freeze) begin
            ifid_nxt_s    = '{pc: skid_pc_s, inst: skid_inst_s, valid: skid_full_s};
            skid_unload_s = 1'b1;
            state_nxt_s   = FETCH;
          end else begin
            state_nxt_s = BUFFERED;
          end
        end
        DRAIN: begin
          if (imem.imem_ready) begin
            state_nxt_s = FETCH;
          end else begin
            state_nxt_s = DRAIN;
          end
        end
        default: state_nxt_s = FETCH;
      endcase
    end
  end

  // Request muxing: idle while a word is parked, stale address while draining.
  always_comb begin
    imem.imem_req  = 1'b1;
    imem.imem_addr = pc_r;
    case (state_r)
      FETCH: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = pc_r;
      end
      BUFFERED: begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_r;
      end
      DRAIN: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = stale_addr_r;
      end
      default: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = pc_r;
      end
    endcase
  end

  assign pc_out     = ifid_r.pc;
  assign inst       = ifid_r.inst;
  assign inst_valid = ifid_r.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed cycle checks followed by randomized
// freeze/branch/latency traffic. A program-order model predicts the stream
// of instructions decode should see; a negedge monitor compares.
module tb_if_fetch_stage;
  import pipeline_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc_out;
  logic [31:0] inst;
  logic        inst_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int n_new    = 0;
  int mem_wait = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] model_pc;

  if_fetch_stage_if mem ();

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (mem),
    .pc_out        (pc_out),
    .inst          (inst),
    .inst_valid    (inst_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program-order model: after a redirect, decode sees target, target+4, ...
  function automatic void model_redirect(input logic [31:0] t);
    exp_pc_q.delete();
    exp_inst_q.delete();
    model_pc = t;
  endfunction

  function automatic void model_refill();
    while (exp_pc_q.size() < 4) begin
      exp_pc_q.push_back(model_pc + 32'd4);
      exp_inst_q.push_back(mem_word(model_pc));
      model_pc = model_pc + 32'd4;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory with mem_wait wait states (0 = ready with the request).
  initial begin
    int cnt;
    cnt = 0;
    mem.imem_ready = 1'b0;
    mem.imem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk);
      #2;
      if (rst === 1'b1 || mem.imem_req !== 1'b1) begin
        mem.imem_ready = 1'b0;
        cnt = 0;
      end else if (cnt >= mem_wait) begin
        mem.imem_ready = 1'b1;
        cnt = 0;
      end else begin
        mem.imem_ready = 1'b0;
        cnt++;
      end
      mem.imem_rdata = mem.imem_ready ? mem_word(mem.imem_addr) : 32'hBAD0_BAD0;
    end
  end

  // Monitor: scoreboard pops on each newly presented instruction, plus
  // flush/hold/bubble/request-stability properties; then feeds the model.
  initial begin
    logic [31:0] p_pc, p_inst, p_addr;
    logic        p_valid, p_req, p_ready, p_rst, p_freeze, p_br;
    p_pc = 32'h0; p_inst = 32'h0; p_addr = 32'h0;
    p_valid = 1'b0; p_req = 1'b0; p_ready = 1'b0;
    p_rst = 1'b1; p_freeze = 1'b0; p_br = 1'b0;
    model_redirect(RST_PC);
    model_refill();
    forever begin
      @(negedge clk);
      if (!p_rst) begin
        if (p_br) begin
          chk("flush_valid", {31'h0, inst_valid}, 32'h0);
          chk("flush_pc", pc_out, 32'h0);
          chk("flush_inst", inst, NOP);
        end else if (p_freeze) begin
          chk("hold_pc", pc_out, p_pc);
          chk("hold_inst", inst, p_inst);
          chk("hold_valid", {31'h0, inst_valid}, {31'h0, p_valid});
        end
        if (p_req && !p_ready) begin
          chk("req_held", {31'h0, mem.imem_req}, 32'h1);
          chk("addr_stable", mem.imem_addr, p_addr);
        end
      end
      if (inst_valid === 1'b1 && (p_valid !== 1'b1 || pc_out !== p_pc)) begin
        n_new++;
        chk("sb_nonempty", 32'(exp_pc_q.size() != 0), 32'h1);
        if (exp_pc_q.size() != 0) begin
          chk("sb_pc", pc_out, exp_pc_q.pop_front());
          chk("sb_inst", inst, exp_inst_q.pop_front());
        end
      end else if (inst_valid === 1'b0) begin
        chk("bubble_pc", pc_out, 32'h0);
        chk("bubble_inst", inst, NOP);
      end
      if (rst === 1'b1) begin
        model_redirect(RST_PC);
      end else if (branch_taken === 1'b1) begin
        model_redirect(branch_target);
      end
      model_refill();
      p_pc = pc_out; p_inst = inst; p_valid = inst_valid;
      p_req = mem.imem_req; p_addr = mem.imem_addr; p_ready = mem.imem_ready;
      p_rst = rst; p_freeze = freeze; p_br = branch_taken;
    end
  end

  task automatic do_reset();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    step();
    step();
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_req", {31'h0, mem.imem_req}, 32'h1);
    chk("rst_addr", mem.imem_addr, RST_PC);
    rst = 1'b0;
  endtask

  // Stimulus.
  initial begin
    int base;
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;

    // Zero-wait streaming.
    mem_wait = 0;
    do_reset();
    chk("t1_addr0", mem.imem_addr, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t1_addr", mem.imem_addr, 32'(4 * k));
      chk("t1_pc_out", pc_out, 32'(4 * k));
      chk("t1_valid", {31'h0, inst_valid}, 32'h1);
      chk("t1_inst", inst, mem_word(32'(4 * (k - 1))));
    end

    // Three-cycle memory.
    mem_wait = 2;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t2_addr_held", mem.imem_addr, 32'h10);
      chk("t2_pc_held", pc_out, 32'h10);
      chk("t2_valid", {31'h0, inst_valid}, 32'h1);
    end
    step();
    chk("t2_addr_next", mem.imem_addr, 32'h14);
    chk("t2_pc_next", pc_out, 32'h14);
    chk("t2_inst", inst, mem_word(32'h10));

    // Freeze while the word at 0x8 completes.
    mem_wait = 0;
    do_reset();
    step();
    step();
    chk("t3_addr8", mem.imem_addr, 32'h8);
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_req_off", {31'h0, mem.imem_req}, 32'h0);
      chk("t3_pc_hold", pc_out, 32'h8);
      chk("t3_inst_hold", inst, mem_word(32'h4));
    end
    freeze = 1'b0;
    step();
    chk("t3_pc_skid", pc_out, 32'hC);
    chk("t3_inst_skid", inst, mem_word(32'h8));
    chk("t3_valid", {31'h0, inst_valid}, 32'h1);
    chk("t3_addr_c", mem.imem_addr, 32'hC);

    // Branch while the fetch of 0x10 is outstanding.
    do_reset();
    for (int k = 0; k < 4; k++) step();
    chk("t4_addr10", mem.imem_addr, 32'h10);
    mem_wait = 2; branch_taken = 1'b1; branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    chk("t4_valid", {31'h0, inst_valid}, 32'h0);
    chk("t4_inst_nop", inst, NOP);
    chk("t4_drain_addr", mem.imem_addr, 32'h10);
    chk("t4_drain_req", {31'h0, mem.imem_req}, 32'h1);
    step();
    chk("t4_drain_addr2", mem.imem_addr, 32'h10);
    step();
    chk("t4_target_addr", mem.imem_addr, 32'h100);
    chk("t4_discarded", {31'h0, inst_valid}, 32'h0);
    mem_wait = 0;
    step();
    chk("t4_pc_out", pc_out, 32'h104);
    chk("t4_inst", inst, mem_word(32'h100));

    // Branch coincident with ready and freeze.
    do_reset();
    step();
    step();
    freeze = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    step();
    freeze = 1'b0; branch_taken = 1'b0;
    chk("t5_valid", {31'h0, inst_valid}, 32'h0);
    chk("t5_addr", mem.imem_addr, 32'h100);
    chk("t5_req", {31'h0, mem.imem_req}, 32'h1);
    step();
    chk("t5_pc_out", pc_out, 32'h104);
    chk("t5_inst", inst, mem_word(32'h100));

    // PC wrap, then reset during a drain.
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    chk("t6_addr_top", mem.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("t6_pc_wrap", pc_out, 32'h0);
    chk("t6_inst_top", inst, mem_word(32'hFFFF_FFFC));
    chk("t6_addr_wrap", mem.imem_addr, 32'h0);
    step();
    chk("t6_addr4", mem.imem_addr, 32'h4);
    mem_wait = 3; branch_taken = 1'b1; branch_target = 32'h200;
    step();
    branch_taken = 1'b0;
    chk("t6_drain_addr", mem.imem_addr, 32'h4);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_wait = 0;
    chk("t6_rst_addr", mem.imem_addr, RST_PC);
    chk("t6_rst_valid", {31'h0, inst_valid}, 32'h0);
    step();
    chk("t6_first_pc", pc_out, RST_PC + 32'h4);
    chk("t6_first_inst", inst, mem_word(RST_PC));

    // Randomized traffic.
    base = n_new;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) mem_wait = $urandom_range(0, 3);
      freeze        = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 19) == 0);
      branch_target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                  : ($urandom & 32'hFFFF_FFFC);
      rst           = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
    step();
    step();
    chk("random_progress", 32'((n_new - base) > 150), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
